eth_rx_header_parser: RTL and testbench

Receive-side Ethernet header parser for the FPGA's byte-wide MAC datapath. It consumes a frame byte stream (`eth_data`/`eth_valid`, one byte per `clk`, frame delimited by `eth_valid` high) and extracts destination MAC, source MAC and EtherType. It filters frames on destination address, then forwards only the payload bytes of accepted frames downstream. It also reports per-frame completion, length and error status, plus saturating statistics counters.

---
 rtl/eth_rx_header_parser.sv | 101 ++++++++++
 tb/tb_eth_rx_header_parser.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_header_parser.sv
// eth_rx_header_parser: captures dest/src MAC and EtherType, filters on dest, forwards payload with status and counters
module eth_rx_header_parser #(
  parameter logic [47:0] MY_MAC       = 48'h000A35010203,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter bit          PROMISC      = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  eth_data,
  input  logic        eth_valid,
  output logic [47:0] rx_dest_mac,
  output logic [47:0] rx_src_mac,
  output logic [15:0] rx_ethertype,
  output logic        hdr_valid,
  output logic [7:0]  payload_data,
  output logic        payload_valid,
  output logic        frame_done,
  output logic [15:0] rx_len,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic [15:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DROP} state_t;
  state_t state, state_nx;
  logic [3:0] idx;
  logic armed;
  logic [15:0] len;
  logic match, start, hdr_end, runt, pay, fin;
  function automatic logic [15:0] sat(input logic [15:0] v);
    return v + {15'd0, v != 16'hFFFF};
  endfunction
  assign match   = PROMISC || rx_dest_mac == MY_MAC || (ACCEPT_BCAST && rx_dest_mac == '1);
  assign start   = state == IDLE && eth_valid && armed;
  assign hdr_end = state == HDR && eth_valid && idx == 4'd13;
  assign runt    = state == HDR && !eth_valid;
  assign pay     = state == PAYLOAD && eth_valid;
  assign fin     = state == PAYLOAD && !eth_valid;
  // armed stays low after reset until eth_valid is seen low, so a frame in flight at release is dropped
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = eth_valid ? (armed ? HDR : DROP) : IDLE;
      HDR:     state_nx = !eth_valid ? IDLE : idx == 4'd13 ? (match ? PAYLOAD : DROP) : HDR;
      PAYLOAD: state_nx = eth_valid ? PAYLOAD : IDLE;
      default: state_nx = eth_valid ? DROP : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      armed         <= 1'b0;
      len           <= '0;
      rx_dest_mac   <= '0;
      rx_src_mac    <= '0;
      rx_ethertype  <= '0;
      hdr_valid     <= 1'b0;
      payload_data  <= '0;
      payload_valid <= 1'b0;
      frame_done    <= 1'b0;
      rx_len        <= '0;
      frame_err     <= 1'b0;
      frame_cnt     <= '0;
      drop_cnt      <= '0;
      err_cnt       <= '0;
    end else begin
      state         <= state_nx;
      armed         <= armed | ~eth_valid;
      hdr_valid     <= hdr_end && match;
      payload_valid <= pay;
      frame_done    <= fin;
      frame_err     <= runt;
      if (pay) begin
        payload_data <= eth_data;
        len          <= sat(len);
      end
      if (hdr_end) len <= '0;
      if (hdr_end && !match) drop_cnt <= sat(drop_cnt);
      if (runt) err_cnt <= sat(err_cnt);
      if (fin) begin
        rx_len    <= len;
        frame_cnt <= sat(frame_cnt);
      end
      if (start) begin
        rx_dest_mac  <= {eth_data, 40'd0};
        rx_src_mac   <= '0;
        rx_ethertype <= '0;
        idx          <= 4'd1;
      end else if (state == HDR && eth_valid) begin
        idx <= idx + 4'd1;
        for (int i = 0; i < 6; i++) begin
          if (idx == 4'(i)) rx_dest_mac[8*(5-i) +: 8] <= eth_data;
          if (idx == 4'(i + 6)) rx_src_mac[8*(5-i) +: 8] <= eth_data;
        end
        if (idx == 4'd12) rx_ethertype[15:8] <= eth_data;
        if (idx == 4'd13) rx_ethertype[7:0] <= eth_data;
      end
    end
  end
endmodule

// File: tb/tb_eth_rx_header_parser.sv
// tb_eth_rx_header_parser: scoreboard bench; expected header/payload/status events are queued with their due cycle
module tb_eth_rx_header_parser;
  localparam logic [47:0] MY  = 48'h000A35010203;
  localparam logic [47:0] SRC = 48'hAABBCCDDEEFF;
  logic clk = 1'b0, rst_n = 1'b0, eth_valid = 1'b0;
  logic [7:0] eth_data = 8'd0;
  logic [47:0] dest, src, p_dest, p_src;
  logic [15:0] etype, rx_len, fcnt, dcnt, ecnt, p_etype, p_rx_len, p_fcnt, p_dcnt, p_ecnt;
  logic [7:0] pdata, p_pdata;
  logic hdr_valid, pvalid, fdone, ferr, p_hdr_valid, p_pvalid, p_fdone, p_ferr;
  typedef struct {int c; logic [111:0] v;} ev_t;
  ev_t q_pay[$], q_hdr[$], q_done[$], q_err[$];
  ev_t m;
  int cyc = 0, checks = 0, errs = 0;
  logic [15:0] e_frame = 0, e_drop = 0, e_err = 0, e_pframe = 0;

  eth_rx_header_parser dut (
    .clk(clk), .rst_n(rst_n), .eth_data(eth_data), .eth_valid(eth_valid),
    .rx_dest_mac(dest), .rx_src_mac(src), .rx_ethertype(etype), .hdr_valid(hdr_valid),
    .payload_data(pdata), .payload_valid(pvalid), .frame_done(fdone), .rx_len(rx_len),
    .frame_err(ferr), .frame_cnt(fcnt), .drop_cnt(dcnt), .err_cnt(ecnt));

  eth_rx_header_parser #(.PROMISC(1'b1)) dut_p (
    .clk(clk), .rst_n(rst_n), .eth_data(eth_data), .eth_valid(eth_valid),
    .rx_dest_mac(p_dest), .rx_src_mac(p_src), .rx_ethertype(p_etype), .hdr_valid(p_hdr_valid),
    .payload_data(p_pdata), .payload_valid(p_pvalid), .frame_done(p_fdone), .rx_len(p_rx_len),
    .frame_err(p_ferr), .frame_cnt(p_fcnt), .drop_cnt(p_dcnt), .err_cnt(p_ecnt));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] inc(input logic [15:0] v);
    return v == 16'hFFFF ? v : v + 16'd1;
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (pvalid) begin
      checks++;
      if (q_pay.size() == 0) begin
        errs++; $display("FAIL payload: unexpected byte %h at cycle %0d", pdata, cyc);
      end else begin
        m = q_pay.pop_front();
        if (m.c !== cyc || m.v[7:0] !== pdata) begin
          errs++; $display("FAIL payload: got %h at cycle %0d, want %h at cycle %0d", pdata, cyc, m.v[7:0], m.c);
        end
      end
    end
    if (hdr_valid) begin
      checks++;
      if (q_hdr.size() == 0) begin
        errs++; $display("FAIL hdr_valid: unexpected pulse at cycle %0d", cyc);
      end else begin
        m = q_hdr.pop_front();
        if (m.c !== cyc || m.v !== {dest, src, etype}) begin
          errs++; $display("FAIL header: got %h at cycle %0d, want %h at cycle %0d", {dest, src, etype}, cyc, m.v, m.c);
        end
      end
    end
    if (fdone) begin
      checks++;
      if (q_done.size() == 0) begin
        errs++; $display("FAIL frame_done: unexpected pulse at cycle %0d", cyc);
      end else begin
        m = q_done.pop_front();
        if (m.c !== cyc || m.v[15:0] !== rx_len) begin
          errs++; $display("FAIL frame_done: rx_len %0d at cycle %0d, want %0d at cycle %0d", rx_len, cyc, m.v[15:0], m.c);
        end
      end
    end
    if (ferr) begin
      checks++;
      if (q_err.size() == 0) begin
        errs++; $display("FAIL frame_err: unexpected pulse at cycle %0d", cyc);
      end else begin
        m = q_err.pop_front();
        if (m.c !== cyc) begin
          errs++; $display("FAIL frame_err: pulse at cycle %0d, want cycle %0d", cyc, m.c);
        end
      end
    end
    if (hdr_valid | fdone | ferr) begin
      checks++;
      if ($countones({hdr_valid, fdone, ferr}) > 1) begin
        errs++; $display("FAIL pulse_overlap: hdr/done/err = %b, want one-hot", {hdr_valid, fdone, ferr});
      end
    end
  end

  task automatic send_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t, input int n);
    logic [111:0] h;
    logic [7:0] b;
    bit acc;
    h = {d, s, t};
    acc = d == MY || d == '1;
    for (int k = 0; k < n; k++) begin
      b = k < 14 ? h[111-8*k -: 8] : 8'(k - 13);
      eth_valid = 1'b1;
      eth_data = b;
      if (acc && k == 13) q_hdr.push_back('{cyc + 1, h});
      if (acc && k >= 14) q_pay.push_back('{cyc + 1, {104'd0, b}});
      @(negedge clk);
    end
    eth_valid = 1'b0;
    if (n < 14) begin
      q_err.push_back('{cyc + 1, '0});
      e_err = inc(e_err);
    end else begin
      e_pframe = inc(e_pframe);
      if (acc) begin
        q_done.push_back('{cyc + 1, 112'(n - 14)});
        e_frame = inc(e_frame);
      end else e_drop = inc(e_drop);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({dest, src, etype, hdr_valid, pdata, pvalid, fdone, rx_len, ferr, fcnt, dcnt, ecnt} !== '0) begin
      errs++; $display("FAIL reset_in: outputs not all zero");
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({dest, src, etype, hdr_valid, pdata, pvalid, fdone, rx_len, ferr, fcnt, dcnt, ecnt} !== '0) begin
      errs++; $display("FAIL reset_out: outputs not all zero after release");
    end
  endtask

  task automatic test_unicast;
    send_frame(MY, SRC, 16'h0800, 18);
    checks++;
    if (fcnt !== e_frame || rx_len !== 16'd4) begin
      errs++; $display("FAIL unicast: frame_cnt %0d rx_len %0d, want %0d and 4", fcnt, rx_len, e_frame);
    end
    checks++;
    if ({dest, src, etype} !== {MY, SRC, 16'h0800}) begin
      errs++; $display("FAIL unicast_hold: fields %h, want %h", {dest, src, etype}, {MY, SRC, 16'h0800});
    end
  endtask

  task automatic test_filter;
    send_frame('1, 48'h020000000001, 16'h0806, 16);
    checks++;
    if (fcnt !== e_frame) begin
      errs++; $display("FAIL bcast: frame_cnt %0d, want %0d", fcnt, e_frame);
    end
    send_frame(48'h112233445566, SRC, 16'h86DD, 22);
    checks++;
    if (dcnt !== e_drop || fcnt !== e_frame) begin
      errs++; $display("FAIL filtered: drop_cnt %0d frame_cnt %0d, want %0d and %0d", dcnt, fcnt, e_drop, e_frame);
    end
    checks++;
    if (p_fcnt !== e_pframe || p_dcnt !== 16'd0) begin
      errs++; $display("FAIL promisc: frame_cnt %0d drop_cnt %0d, want %0d and 0", p_fcnt, p_dcnt, e_pframe);
    end
  endtask

  task automatic test_runt;
    send_frame(MY, SRC, 16'h0800, 12);
    checks++;
    if (ecnt !== e_err || fcnt !== e_frame) begin
      errs++; $display("FAIL runt: err_cnt %0d frame_cnt %0d, want %0d and %0d", ecnt, fcnt, e_err, e_frame);
    end
    send_frame(MY, 48'h0123456789AB, 16'h0800, 17);
    checks++;
    if (fcnt !== e_frame || rx_len !== 16'd3) begin
      errs++; $display("FAIL after_runt: frame_cnt %0d rx_len %0d, want %0d and 3", fcnt, rx_len, e_frame);
    end
  endtask

  task automatic test_back_to_back;
    send_frame(MY, SRC, 16'h88B5, 14);
    checks++;
    if (rx_len !== 16'd0 || fcnt !== e_frame) begin
      errs++; $display("FAIL hdr_only: rx_len %0d frame_cnt %0d, want 0 and %0d", rx_len, fcnt, e_frame);
    end
    for (int i = 0; i < 2; i++) begin
      send_frame(MY, SRC, 16'(16'h0800 + i), 20);
      checks++;
      if (rx_len !== 16'd6 || fcnt !== e_frame) begin
        errs++; $display("FAIL back_to_back%0d: rx_len %0d frame_cnt %0d, want 6 and %0d", i, rx_len, fcnt, e_frame);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [111:0] h;
    h = {MY, SRC, 16'h0800};
    for (int k = 0; k < 50; k++) begin
      eth_valid = 1'b1;
      eth_data = k < 14 ? h[111-8*k -: 8] : 8'(k + 100);
      if (k == 13) q_hdr.push_back('{cyc + 1, h});
      if (k >= 14 && k < 44) q_pay.push_back('{cyc + 1, {104'd0, eth_data}});
      if (k == 44) begin
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({dest, src, etype, hdr_valid, pdata, pvalid, fdone, rx_len, ferr, fcnt, dcnt, ecnt} !== '0) begin
          errs++; $display("FAIL reset_async: outputs not all zero during reset");
        end
      end
      if (k == 46) rst_n = 1'b1;
      @(negedge clk);
    end
    eth_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({dest, src, etype, hdr_valid, pdata, pvalid, fdone, rx_len, ferr, fcnt, dcnt, ecnt} !== '0) begin
      errs++; $display("FAIL reset_drop: outputs not zero after in-flight frame");
    end
    e_frame = 0; e_drop = 0; e_err = 0; e_pframe = 0;
    send_frame(MY, SRC, 16'h0800, 20);
    checks++;
    if (fcnt !== e_frame || rx_len !== 16'd6) begin
      errs++; $display("FAIL reset_next: frame_cnt %0d rx_len %0d, want %0d and 6", fcnt, rx_len, e_frame);
    end
  endtask

  task automatic test_saturation;
    force dut.drop_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.drop_cnt;
    e_drop = 16'hFFFE;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      send_frame(48'h112233445566, SRC, 16'h0800, 15);
      checks++;
      if (dcnt !== e_drop) begin
        errs++; $display("FAIL saturate%0d: drop_cnt %h, want %h", i, dcnt, e_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_filter();
    test_runt();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    repeat (3) @(negedge clk);
    checks++;
    if (q_pay.size() + q_hdr.size() + q_done.size() + q_err.size() != 0) begin
      errs++; $display("FAIL leftover: %0d payload %0d hdr %0d done %0d err events never seen, want 0",
                       q_pay.size(), q_hdr.size(), q_done.size(), q_err.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
